// File: rtl/epl_correlator.sv
// ---------------------------------------------------------------------------
// epl_correlator
//   Early/prompt/late correlator for one tracking channel. Each baseband I/Q
//   sample is multiplied by the early, prompt and late C/A chips (chip 0 means
//   +1, chip 1 means -1). The six products (IE, IP, IL, QE, QP, QL) are
//   integrated with saturation over one code period. On dump_enable the sums
//   are latched to the outputs and the accumulators restart.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   prn_key_enable     synchronous channel restart (clears all state)
//   sample_enable      i_bb/q_bb and chips valid this cycle
//   i_bb, q_bb         signed baseband samples (IN_W bits)
//   early/prompt/late  code chips aligned with the sample
//   dump_enable        code-period boundary pulse
//   status_read        bus has consumed the latched results
//   i_*/q_*            latched correlations (ACC_W bits, signed)
//   accum_ready        new results latched and not yet read
//   accum_ovf          a latched result saturated during its period
//   missed_dump        a dump overwrote results that were never read
// ---------------------------------------------------------------------------
module epl_correlator #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             prn_key_enable,
  input  logic             sample_enable,
  input  logic [IN_W-1:0]  i_bb,
  input  logic [IN_W-1:0]  q_bb,
  input  logic             early,
  input  logic             prompt,
  input  logic             late,
  input  logic             dump_enable,
  input  logic             status_read,
  output logic [ACC_W-1:0] i_early,
  output logic [ACC_W-1:0] i_prompt,
  output logic [ACC_W-1:0] i_late,
  output logic [ACC_W-1:0] q_early,
  output logic [ACC_W-1:0] q_prompt,
  output logic [ACC_W-1:0] q_late,
  output logic             accum_ready,
  output logic             accum_ovf,
  output logic             missed_dump
);

  // Sums are formed one bit wider than the accumulator so that overflow shows
  // up as a disagreement between the two top bits.
  localparam int SW = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Index map shared by all arrays: 0 IE, 1 IP, 2 IL, 3 QE, 4 QP, 5 QL.
  logic signed [IN_W-1:0]  samp_s    [6];
  logic                    chip_s    [6];
  logic signed [SW-1:0]    prod_s    [6];
  logic signed [SW-1:0]    sum_s     [6];
  logic signed [ACC_W-1:0] sat_s     [6];
  logic                    any_sat_s;

  logic signed [ACC_W-1:0] acc_r     [6];
  logic signed [ACC_W-1:0] res_r     [6];
  logic                    ovf_r;
  logic                    ready_r;
  logic                    ovf_out_r;
  logic                    missed_r;

  // Sign-extend first, then negate: -(-2^(IN_W-1)) is representable at SW bits.
  function automatic logic signed [SW-1:0] chip_product(
    input logic signed [IN_W-1:0] s,
    input logic                   c
  );
    logic signed [SW-1:0] ext;
    ext = {{(SW-IN_W){s[IN_W-1]}}, s};
    if (c) begin
      chip_product = -ext;
    end else begin
      chip_product = ext;
    end
  endfunction

  // Clamp a widened sum back into the accumulator range.
  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [SW-1:0] v);
    if (v[SW-1] == v[SW-2]) begin
      saturate = v[ACC_W-1:0];
    end else if (v[SW-1]) begin
      saturate = ACC_MIN;
    end else begin
      saturate = ACC_MAX;
    end
  endfunction

  assign samp_s[0] = $signed(i_bb);
  assign samp_s[1] = $signed(i_bb);
  assign samp_s[2] = $signed(i_bb);
  assign samp_s[3] = $signed(q_bb);
  assign samp_s[4] = $signed(q_bb);
  assign samp_s[5] = $signed(q_bb);
  assign chip_s[0] = early;
  assign chip_s[1] = prompt;
  assign chip_s[2] = late;
  assign chip_s[3] = early;
  assign chip_s[4] = prompt;
  assign chip_s[5] = late;

  // Products, widened sums, saturated next values and the overflow summary.
  always_comb begin
    any_sat_s = 1'b0;
    for (int k = 0; k < 6; k++) begin
      prod_s[k] = chip_product(samp_s[k], chip_s[k]);
      sum_s[k]  = {acc_r[k][ACC_W-1], acc_r[k]} + prod_s[k];
      sat_s[k]  = saturate(sum_s[k]);
      if (sum_s[k][SW-1] != sum_s[k][SW-2]) begin
        any_sat_s = 1'b1;
      end else begin
        any_sat_s = any_sat_s;
      end
    end
  end

  // Accumulators, dump latches and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 6; k++) begin
        acc_r[k] <= '0;
        res_r[k] <= '0;
      end
      ovf_r     <= 1'b0;
      ready_r   <= 1'b0;
      ovf_out_r <= 1'b0;
      missed_r  <= 1'b0;
    end else if (prn_key_enable) begin
      for (int k = 0; k < 6; k++) begin
        acc_r[k] <= '0;
        res_r[k] <= '0;
      end
      ovf_r     <= 1'b0;
      ready_r   <= 1'b0;
      ovf_out_r <= 1'b0;
      missed_r  <= 1'b0;
    end else begin
      if (dump_enable) begin
        // The sample arriving with the dump opens the next period; a single
        // product is far inside the accumulator range, so no clamp is needed.
        for (int k = 0; k < 6; k++) begin
          res_r[k] <= acc_r[k];
          if (sample_enable) begin
            acc_r[k] <= prod_s[k][ACC_W-1:0];
          end else begin
            acc_r[k] <= '0;
          end
        end
        ovf_out_r <= ovf_r;
        ovf_r     <= 1'b0;
      end else if (sample_enable) begin
        for (int k = 0; k < 6; k++) begin
          acc_r[k] <= sat_s[k];
        end
        ovf_r <= ovf_r | any_sat_s;
      end else begin
        ovf_r <= ovf_r;
      end

      if (dump_enable) begin
        ready_r <= 1'b1;
      end else if (status_read) begin
        ready_r <= 1'b0;
      end else begin
        ready_r <= ready_r;
      end

      // A coincident read means the old results were consumed, so no miss.
      if (dump_enable && ready_r && !status_read) begin
        missed_r <= 1'b1;
      end else if (status_read) begin
        missed_r <= 1'b0;
      end else begin
        missed_r <= missed_r;
      end
    end
  end

  assign i_early     = res_r[0];
  assign i_prompt    = res_r[1];
  assign i_late      = res_r[2];
  assign q_early     = res_r[3];
  assign q_prompt    = res_r[4];
  assign q_late      = res_r[5];
  assign accum_ready = ready_r;
  assign accum_ovf   = ovf_out_r;
  assign missed_dump = missed_r;

endmodule

// File: tb/tb_epl_correlator.sv
// ---------------------------------------------------------------------------
// tb_epl_correlator
//   Directed self-checking bench for epl_correlator (IN_W=3, ACC_W=16).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   after that settle time, well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_epl_correlator;

  logic        clk;
  logic        rstn;
  logic        prn_key_enable;
  logic        sample_enable;
  logic [2:0]  i_bb;
  logic [2:0]  q_bb;
  logic        early;
  logic        prompt;
  logic        late;
  logic        dump_enable;
  logic        status_read;
  logic [15:0] i_early;
  logic [15:0] i_prompt;
  logic [15:0] i_late;
  logic [15:0] q_early;
  logic [15:0] q_prompt;
  logic [15:0] q_late;
  logic        accum_ready;
  logic        accum_ovf;
  logic        missed_dump;

  int tests_run;
  int tests_failed;

  epl_correlator #(.IN_W(3), .ACC_W(16)) dut (
    .clk(clk), .rstn(rstn), .prn_key_enable(prn_key_enable),
    .sample_enable(sample_enable), .i_bb(i_bb), .q_bb(q_bb),
    .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .status_read(status_read),
    .i_early(i_early), .i_prompt(i_prompt), .i_late(i_late),
    .q_early(q_early), .q_prompt(q_prompt), .q_late(q_late),
    .accum_ready(accum_ready), .accum_ovf(accum_ovf), .missed_dump(missed_dump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input int q, input logic e, input logic p, input logic l);
    i_bb   = 3'(i);
    q_bb   = 3'(q);
    early  = e;
    prompt = p;
    late   = l;
  endtask

  task automatic run_samples(input int n);
    sample_enable = 1'b1;
    for (int n_i = 0; n_i < n; n_i++) tick();
    sample_enable = 1'b0;
  endtask

  task automatic dump();
    dump_enable = 1'b1;
    tick();
    dump_enable = 1'b0;
  endtask

  task automatic read_status();
    status_read = 1'b1;
    tick();
    status_read = 1'b0;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rstn           = 1'b0;
    prn_key_enable = 1'b0;
    sample_enable  = 1'b0;
    dump_enable    = 1'b0;
    status_read    = 1'b0;
    set_in(0, 0, 1'b0, 1'b0, 1'b0);
    #12;
    check_val("rst_i_early", $signed(i_early), 0);
    check_val("rst_q_late", $signed(q_late), 0);
    check_val("rst_ready", accum_ready, 0);
    check_val("rst_ovf", accum_ovf, 0);
    check_val("rst_missed", missed_dump, 0);
    rstn = 1'b1;
    tick();

    // Basic correlation: I=+3, Q=-2, late chip inverted.
    set_in(3, -2, 1'b0, 1'b0, 1'b1);
    run_samples(10);
    dump();
    check_val("t2_i_early", $signed(i_early), 30);
    check_val("t2_i_prompt", $signed(i_prompt), 30);
    check_val("t2_i_late", $signed(i_late), -30);
    check_val("t2_q_early", $signed(q_early), -20);
    check_val("t2_q_prompt", $signed(q_prompt), -20);
    check_val("t2_q_late", $signed(q_late), 20);
    check_val("t2_ready", accum_ready, 1);
    check_val("t2_ovf", accum_ovf, 0);
    check_val("t2_missed", missed_dump, 0);
    read_status();
    check_val("t2_ready_clr", accum_ready, 0);

    // Asynchronous reset mid-accumulation, then a fresh period from zero.
    run_samples(100);
    #2;
    rstn = 1'b0;
    #2;
    check_val("t1_i_early_async", $signed(i_early), 0);
    check_val("t1_q_late_async", $signed(q_late), 0);
    check_val("t1_ready_async", accum_ready, 0);
    #2;
    rstn = 1'b1;
    tick();
    set_in(1, 1, 1'b0, 1'b0, 1'b0);
    run_samples(5);
    dump();
    check_val("t1_i_prompt_restart", $signed(i_prompt), 5);
    check_val("t1_q_prompt_restart", $signed(q_prompt), 5);
    read_status();

    // Positive saturation: -4 times chip 1 gives +4 per sample.
    set_in(-4, 0, 1'b1, 1'b1, 1'b1);
    run_samples(8192);
    dump();
    check_val("t3_i_early_sat", $signed(i_early), 32767);
    check_val("t3_i_late_sat", $signed(i_late), 32767);
    check_val("t3_q_prompt", $signed(q_prompt), 0);
    check_val("t3_ovf", accum_ovf, 1);
    read_status();
    set_in(1, 0, 1'b0, 1'b0, 1'b0);
    run_samples(3);
    dump();
    check_val("t3_i_early_clean", $signed(i_early), 3);
    check_val("t3_ovf_clear", accum_ovf, 0);
    read_status();

    // Two dumps without a read: second period wins, miss flagged.
    run_samples(2);
    dump();
    run_samples(7);
    dump();
    check_val("t4_missed", missed_dump, 1);
    check_val("t4_i_prompt", $signed(i_prompt), 7);
    check_val("t4_ready", accum_ready, 1);
    read_status();
    check_val("t4_ready_clr", accum_ready, 0);
    check_val("t4_missed_clr", missed_dump, 0);

    // Dump coincident with a sample and a read.
    run_samples(4);
    dump();
    run_samples(4);
    sample_enable = 1'b1;
    dump_enable   = 1'b1;
    status_read   = 1'b1;
    tick();
    sample_enable = 1'b0;
    dump_enable   = 1'b0;
    status_read   = 1'b0;
    check_val("t5_i_prompt_excl", $signed(i_prompt), 4);
    check_val("t5_ready_kept", accum_ready, 1);
    check_val("t5_missed", missed_dump, 0);
    dump();
    check_val("t5_next_period", $signed(i_prompt), 1);
    check_val("t5_missed_set", missed_dump, 1);
    read_status();

    // Channel restart overrides a coincident dump.
    run_samples(3);
    prn_key_enable = 1'b1;
    dump_enable    = 1'b1;
    tick();
    prn_key_enable = 1'b0;
    dump_enable    = 1'b0;
    check_val("t6_i_prompt", $signed(i_prompt), 0);
    check_val("t6_ready", accum_ready, 0);
    check_val("t6_missed", missed_dump, 0);
    dump();
    check_val("t6_acc_cleared", $signed(i_prompt), 0);
    check_val("t6_ready_after", accum_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
